max_cut_sweep_ctrl: RTL and testbench
=====================================

Name: max_cut_sweep_ctrl

Overview:
- Sequential controller/scheduler for the max-cut evaluation datapath.
- Takes a programmable undirected graph on N_NODES nodes and sweeps every 2^N_NODES node partition, evaluating one candidate edge per cycle.
- Tracks the best cut size and the first partition that reaches it, and reports whether the best cut meets a programmable threshold.
- Replaces the purely combinational single-assignment check with a start/done-controlled exhaustive search engine.

Parameters:
- N_NODES, 5, number of graph nodes. Legal range 2..8.
- CNT_W, 4, width of the cut counters. Must satisfy 2^CNT_W > N_EDGES.
- Derived, not overridable: N_EDGES = N_NODES*(N_NODES-1)/2, default 10.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write enable for the edge mask and threshold; honoured only in IDLE.
- cfg_edges  input  N_EDGES  edge mask; bit k = 1 means edge k is present.
- cfg_thresh  input  CNT_W  minimum cut size that counts as success.
- start  input  1  single-cycle request to begin a sweep.
- busy  output  1  high while a sweep is in progress (EVAL or DONE).
- done  output  1  one-cycle pulse when the sweep completes.
- best_cut  output  CNT_W  largest cut found in the last sweep.
- best_part  output  N_NODES  partition achieving best_cut; bit i = side of node i.
- thresh_met  output  1  registered result of best_cut >= threshold.

Behaviour:
- Edge index k enumerates unordered pairs (i,j), i<j, lexicographically: (0,1)=0, (0,2)=1, …, (N-2,N-1)=N_EDGES-1.
- Reset (asynchronous, any state, including mid-sweep) clears everything:
  - busy=0, done=0, best_cut=0, best_part=0, thresh_met=0.
  - Edge mask register=0, threshold register=0, all counters=0.
  - FSM returns to IDLE.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - If cfg_we, latch cfg_edges and cfg_thresh.
  - If start (with or without cfg_we in the same cycle), go to EVAL with:
    - part=0, edge=0, run_cnt=0;
    - best_cut=0, best_part=0, thresh_met=0.
  - When cfg_we and start are both high, the new config is latched and used by that sweep.
- EVAL, one edge per cycle:
  - Edge k is cut when mask[k]=1 and part[i]!=part[j].
  - Absent edges still consume a cycle, so latency is fixed.
  - cand = run_cnt + cut_bit.
  - If edge < N_EDGES-1: run_cnt <= cand, edge++.
  - If edge == N_EDGES-1 (partition complete):
    - If cand > best_cut (strict), update best_cut <= cand and best_part <= part. On ties the earlier, lower-numbered partition wins.
    - run_cnt <= 0, edge <= 0.
    - If part == 2^N_NODES-1, go to DONE; otherwise part++.
- DONE, one cycle:
  - done=1.
  - thresh_met <= (best_cut >= threshold).
  - Return to IDLE.
- Latency: with start sampled at clock edge T, done is high for exactly one cycle, in the cycle following edge T + 2^N_NODES*N_EDGES + 1 (T+321 at defaults).
- Outputs hold their values after DONE until the next accepted start.
- start and cfg_we are ignored while busy. A start during DONE is dropped and is not queued.
- Counters never overflow, because 2^CNT_W > N_EDGES. An empty mask gives best_cut=0, best_part=0.
- Threshold 0 always gives thresh_met=1. A threshold above N_EDGES always gives thresh_met=0.
- busy=1 throughout EVAL and DONE, and falls together with the return to IDLE.

Test Plan:
- Reference graph, edges {0-1,0-2,0-3,1-4,2-3,3-4}: cfg_edges=10'h2C7, thresh=4, start.
  - Expected: done exactly 321 cycles after start; best_cut=5; best_part=5'b01010; thresh_met=1.
- Same graph, thresh=6 → best_cut=5, thresh_met=0.
- cfg_edges=0, thresh=0 → best_cut=0, best_part=0, thresh_met=1.
- Complete graph K5, cfg_edges=10'h3FF, thresh=6 → best_cut=6, best_part=5'b00011, thresh_met=1.
- Mid-sweep behaviour:
  - Pulse start and cfg_we (new mask) at cycle 100 of a sweep → both are ignored; results match the original config.
  - Assert rst at cycle 150 → busy, done and all outputs drop to 0 immediately; FSM is in IDLE.
  - A new start then completes normally in 321 cycles.
- Back-to-back:
  - start asserted during the DONE cycle is ignored.
  - start on the first IDLE cycle after DONE is accepted; the second sweep reproduces identical results.

Source files
------------

// File: rtl/max_cut_sweep_ctrl.sv
// Exhaustive max-cut search engine: sweeps every node partition, evaluating one
// candidate edge per cycle, and keeps the first partition reaching the best cut.
module max_cut_sweep_ctrl #(
    parameter int  N_NODES = 5,
    parameter int  CNT_W   = 4,
    localparam int N_EDGES = N_NODES * (N_NODES - 1) / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [N_EDGES-1:0] cfg_edges,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   best_cut,
    output logic [N_NODES-1:0] best_part,
    output logic               thresh_met
);
    localparam int EW = (N_EDGES > 1) ? $clog2(N_EDGES) : 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(N_EDGES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_EDGES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [N_NODES-1:0] part_q, part_d;
    logic [EW-1:0]      edge_q, edge_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   best_cut_q, best_cut_d;
    logic [N_NODES-1:0] best_part_q, best_part_d;
    logic               thresh_met_q, thresh_met_d;

    logic [N_EDGES-1:0] cut_vec;
    logic [CNT_W-1:0]   cand;

    // Edge k for pair (i,j), i<j, in lexicographic order.
    for (genvar i = 0; i < N_NODES - 1; i++) begin : g_i
        for (genvar j = i + 1; j < N_NODES; j++) begin : g_j
            localparam int K = i * N_NODES - i * (i + 1) / 2 + (j - i - 1);
            assign cut_vec[K] = mask_q[K] & (part_q[i] ^ part_q[j]);
        end
    end

    assign cand = run_cnt_q + {{(CNT_W-1){1'b0}}, cut_vec[edge_q]};

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        thresh_d     = thresh_q;
        part_d       = part_q;
        edge_d       = edge_q;
        run_cnt_d    = run_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_cut_d   = best_cut_q;
        best_part_d  = best_part_q;
        thresh_met_d = thresh_met_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    mask_d   = cfg_edges;
                    thresh_d = cfg_thresh;
                end
                if (start) begin
                    state_d      = S_EVAL;
                    busy_d       = 1'b1;
                    part_d       = '0;
                    edge_d       = '0;
                    run_cnt_d    = '0;
                    best_cut_d   = '0;
                    best_part_d  = '0;
                    thresh_met_d = 1'b0;
                end
            end
            S_EVAL: begin
                if (edge_q != LAST_EDGE) begin
                    run_cnt_d = cand;
                    edge_d    = edge_q + 1'b1;
                end else begin
                    // Strict compare keeps the lowest-numbered partition on ties.
                    if (cand > best_cut_q) begin
                        best_cut_d  = cand;
                        best_part_d = part_q;
                    end
                    run_cnt_d = '0;
                    edge_d    = '0;
                    if (part_q == '1) state_d = S_DONE;
                    else              part_d  = part_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d       = 1'b1;
                thresh_met_d = (best_cut_q >= thresh_q);
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            thresh_q     <= '0;
            part_q       <= '0;
            edge_q       <= '0;
            run_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_cut_q   <= '0;
            best_part_q  <= '0;
            thresh_met_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            thresh_q     <= thresh_d;
            part_q       <= part_d;
            edge_q       <= edge_d;
            run_cnt_q    <= run_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_cut_q   <= best_cut_d;
            best_part_q  <= best_part_d;
            thresh_met_q <= thresh_met_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign best_cut   = best_cut_q;
    assign best_part  = best_part_q;
    assign thresh_met = thresh_met_q;
endmodule

// File: tb/tb_max_cut_sweep_ctrl.sv
// Randomized bench for max_cut_sweep_ctrl against a brute-force max-cut model.
module tb_max_cut_sweep_ctrl;
    localparam int N   = 5;
    localparam int NE  = N * (N - 1) / 2;
    localparam int CW  = 4;
    localparam int LAT = (1 << N) * NE + 1;
    localparam logic [NE-1:0] REF_G = 10'h2C7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [NE-1:0] cfg_edges = '0;
    logic [CW-1:0] cfg_thresh = '0;
    logic          start = 1'b0;
    logic          busy, done, thresh_met;
    logic [CW-1:0] best_cut;
    logic [N-1:0]  best_part;

    int vec_cnt = 0;
    int err_cnt = 0;

    max_cut_sweep_ctrl #(.N_NODES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_edges(cfg_edges),
        .cfg_thresh(cfg_thresh), .start(start), .busy(busy), .done(done),
        .best_cut(best_cut), .best_part(best_part), .thresh_met(thresh_met)
    );

    always #5 clk = ~clk;

    // Brute force: try every partition, count edges whose endpoints differ.
    task automatic model(input logic [NE-1:0] m, input int th,
                         output int bc, output int bp, output bit tm);
        bc = 0;
        bp = 0;
        for (int p = 0; p < (1 << N); p++) begin
            int c = 0;
            int k = 0;
            for (int i = 0; i < N - 1; i++)
                for (int j = i + 1; j < N; j++) begin
                    if (m[k] && (((p >> i) & 1) != ((p >> j) & 1))) c++;
                    k++;
                end
            if (c > bc) begin
                bc = c;
                bp = p;
            end
        end
        tm = (bc >= th);
    endtask

    // Launch one sweep from IDLE and wait (bounded) for done.
    task automatic run_sweep(input bit we, input logic [NE-1:0] m, input logic [CW-1:0] th,
                             output int lat);
        @(posedge clk); #1;
        cfg_we = we; cfg_edges = m; cfg_thresh = th; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({busy, done, best_cut, best_part, thresh_met} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outs got=%b want=0", {busy, done, best_cut, best_part, thresh_met});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reference();
        int lat, bc, bp;
        bit tm;
        model(REF_G, 4, bc, bp, tm);
        run_sweep(1'b1, REF_G, 4'd4, lat);
        vec_cnt++;
        if (lat != LAT) begin
            err_cnt++;
            $display("FAIL ref_latency got=%0d want=%0d", lat, LAT);
        end
        vec_cnt++;
        if (best_cut !== CW'(bc) || bc != 5) begin
            err_cnt++;
            $display("FAIL ref_best_cut got=%0d model=%0d want=5", best_cut, bc);
        end
        vec_cnt++;
        if (best_part !== N'(bp) || bp != 5'b01010) begin
            err_cnt++;
            $display("FAIL ref_best_part got=%b model=%0d want=01010", best_part, bp);
        end
        vec_cnt++;
        if (thresh_met !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ref_thresh_busy tm=%b busy=%b want 1 0", thresh_met, busy);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (done !== 1'b0 || best_cut !== CW'(bc)) begin
            err_cnt++;
            $display("FAIL ref_done_pulse_hold done=%b cut=%0d want 0 %0d", done, best_cut, bc);
        end
    endtask

    task automatic test_thresh();
        int lat, bc, bp;
        bit tm;
        int ths[2] = '{6, 15};
        foreach (ths[t]) begin
            model(REF_G, ths[t], bc, bp, tm);
            run_sweep(1'b1, REF_G, CW'(ths[t]), lat);
            vec_cnt++;
            if (best_cut !== CW'(bc) || thresh_met !== tm || tm !== 1'b0) begin
                err_cnt++;
                $display("FAIL thresh_%0d cut=%0d tm=%b want %0d %b", ths[t], best_cut, thresh_met, bc, tm);
            end
        end
    endtask

    task automatic test_empty_and_k5();
        int lat;
        run_sweep(1'b1, '0, 4'd0, lat);
        vec_cnt++;
        if (best_cut !== 0 || best_part !== 0 || thresh_met !== 1'b1 || lat != LAT) begin
            err_cnt++;
            $display("FAIL empty cut=%0d part=%b tm=%b lat=%0d want 0 0 1 %0d", best_cut, best_part, thresh_met, lat, LAT);
        end
        run_sweep(1'b1, '1, 4'd6, lat);
        vec_cnt++;
        if (best_cut !== 6 || best_part !== 5'b00011 || thresh_met !== 1'b1) begin
            err_cnt++;
            $display("FAIL k5 cut=%0d part=%b tm=%b want 6 00011 1", best_cut, best_part, thresh_met);
        end
    endtask

    task automatic test_random();
        int lat, bc, bp;
        bit tm;
        logic [NE-1:0] m;
        logic [CW-1:0] th;
        for (int r = 0; r < 6; r++) begin
            m  = NE'($urandom);
            th = CW'($urandom_range(0, 15));
            model(m, int'(th), bc, bp, tm);
            run_sweep(1'b1, m, th, lat);
            vec_cnt++;
            if (lat != LAT || best_cut !== CW'(bc) || best_part !== N'(bp) || thresh_met !== tm) begin
                err_cnt++;
                $display("FAIL rand_%0d m=%h th=%0d got lat=%0d cut=%0d part=%b tm=%b want %0d %0d %b %b",
                         r, m, th, lat, best_cut, best_part, thresh_met, LAT, bc, N'(bp), tm);
            end
        end
    endtask

    task automatic test_mid_sweep();
        int lat;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_edges = REF_G; cfg_thresh = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0; lat = 0;
        repeat (99) begin @(posedge clk); #1; lat++; end
        cfg_we = 1'b1; cfg_edges = '1; cfg_thresh = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        cfg_we = 1'b0; start = 1'b0;
        while (!done && lat < 2000) begin @(posedge clk); #1; lat++; end
        vec_cnt++;
        if (lat != LAT || best_cut !== 5 || best_part !== 5'b01010 || thresh_met !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_ignore lat=%0d cut=%0d part=%b tm=%b want %0d 5 01010 1", lat, best_cut, best_part, thresh_met, LAT);
        end
        run_sweep(1'b0, '1, 4'd0, lat);
        vec_cnt++;
        if (best_cut !== 5 || thresh_met !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_cfg_kept cut=%0d tm=%b want 5 1", best_cut, thresh_met);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_edges = '1; cfg_thresh = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        repeat (149) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({busy, done, best_cut, best_part, thresh_met} !== '0) begin
            err_cnt++;
            $display("FAIL rst_mid_async got=%b want=0", {busy, done, best_cut, best_part, thresh_met});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_idle busy=%b want 0", busy);
        end
        run_sweep(1'b0, '1, 4'd9, lat);
        vec_cnt++;
        if (lat != LAT || best_cut !== 0 || best_part !== 0 || thresh_met !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_mid_rerun lat=%0d cut=%0d part=%b tm=%b want %0d 0 0 1", lat, best_cut, best_part, thresh_met, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, bp;
        bit tm;
        logic [CW-1:0] c1;
        logic [N-1:0]  p1;
        model('1, 6, bc, bp, tm);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_edges = '1; cfg_thresh = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_done_cycle done=%b busy=%b want 1 0", done, busy);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_not_queued busy=%b done=%b want 0 0", busy, done);
        end
        run_sweep(1'b0, '0, 4'd0, lat);
        c1 = best_cut;
        p1 = best_part;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1 || best_cut !== 0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_accept busy=%b cut=%0d done=%b want 1 0 0", busy, best_cut, done);
        end
        lat = 0;
        while (!done && lat < 2000) begin @(posedge clk); #1; lat++; end
        vec_cnt++;
        if (lat != LAT || best_cut !== c1 || best_part !== p1 || c1 !== CW'(bc) ||
            p1 !== N'(bp) || thresh_met !== tm) begin
            err_cnt++;
            $display("FAIL b2b_repeat lat=%0d cut=%0d/%0d part=%b/%b tm=%b want %0d %0d %b %b",
                     lat, best_cut, c1, best_part, p1, thresh_met, LAT, bc, N'(bp), tm);
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_thresh();
        test_empty_and_k5();
        test_random();
        test_mid_sweep();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
